// File: rtl/vga_render_if.sv
// Bundle between the VGA renderer and the game-loop stage: scan coordinates out,
// pixel class back, plus the registered VGA pins and the per-frame strobe.
interface vga_render_if;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic [3:0] category;
   logic       video_en;
   logic       hsync;
   logic       vsync;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       frame_tick;

   modport master (
      output pixel_x, pixel_y, hsync, vsync, vga_r, vga_g, vga_b, frame_tick,
      input  category, video_en
   );

   modport slave (
      input  pixel_x, pixel_y, hsync, vsync, vga_r, vga_g, vga_b, frame_tick,
      output category, video_en
   );
endinterface

// File: rtl/vga_render.sv
// VGA scan generator and colouriser: 25 MHz pixel timing derived from the 100 MHz clock,
// with hsync, vsync and RGB registered together from the same pixel coordinates.
module vga_render #(
   parameter int H_VIS  = 640,
   parameter int V_VIS  = 480,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic         clk_100mhz,
   input  logic         rst_n,
   vga_render_if.master bus
);
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
   localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
   localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

   logic [1:0]  div;
   logic [9:0]  h;
   logic [9:0]  v;
   logic        pix_en;
   logic        h_wrap;
   logic        v_wrap;
   logic        visible;
   logic [11:0] rgb_d;
   logic        hsync_q;
   logic        vsync_q;
   logic [11:0] rgb_q;
   logic        frame_tick_q;

   // Game-loop contract: pixel_x/pixel_y change on a pix_en edge; category must be
   // valid one clock later and is sampled only at the following pix_en, 3 clocks on.
   assign pix_en  = (div == 2'd3);
   assign h_wrap  = (h == H_LAST);
   assign v_wrap  = (v == V_LAST);
   assign visible = (h < H_VIS_W) && (v < V_VIS_W);

   always_comb begin
      rgb_d = 12'h000;
      if (visible && bus.video_en) begin
         case (bus.category)
            4'd0:    rgb_d = 12'h000;
            4'd1:    rgb_d = 12'h888;
            4'd2:    rgb_d = 12'h0F0;
            default: rgb_d = 12'hF0F;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         div          <= 2'd0;
         h            <= 10'd0;
         v            <= 10'd0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         rgb_q        <= 12'h000;
         frame_tick_q <= 1'b0;
      end else begin
         div          <= div + 2'd1;
         frame_tick_q <= pix_en && (h == H_VIS_LAST) && (v == V_VIS_LAST);
         if (pix_en) begin
            h <= h_wrap ? 10'd0 : h + 10'd1;
            if (h_wrap) begin
               v <= v_wrap ? 10'd0 : v + 10'd1;
            end
            // Sync and colour share one register stage so they describe the same pixel.
            hsync_q <= !((h >= HS_START) && (h < HS_END));
            vsync_q <= !((v >= VS_START) && (v < VS_END));
            rgb_q   <= rgb_d;
         end
      end
   end

   assign bus.pixel_x    = h;
   assign bus.pixel_y    = v;
   assign bus.hsync      = hsync_q;
   assign bus.vsync      = vsync_q;
   assign bus.vga_r      = rgb_q[11:8];
   assign bus.vga_g      = rgb_q[7:4];
   assign bus.vga_b      = rgb_q[3:0];
   assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_render.sv
// Bench for vga_render on a shrunken raster so whole frames fit in a short run;
// outputs are predicted from an absolute pixel count since reset.
module tb_vga_render;
   localparam int HV = 20, HFP = 4, HS = 6, HBP = 5;
   localparam int VV = 12, VFP = 2, VS = 2, VBP = 3;
   localparam int HT = HV + HFP + HS + HBP;
   localparam int VT = VV + VFP + VS + VBP;
   localparam int LINE_CLKS  = HT * 4;
   localparam int FRAME_CLKS = HT * VT * 4;
   localparam int NVEC = 12;

   typedef struct {
      int          x;
      int          y;
      logic [3:0]  cat;
      logic        en;
      logic [11:0] rgb;
   } vec_t;

   logic clk_100mhz = 1'b0;
   logic rst_n      = 1'b0;

   vga_render_if bus ();

   vga_render #(
      .H_VIS(HV), .V_VIS(VV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .clk_100mhz(clk_100mhz),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   // clock / reset
   always #5 clk_100mhz = ~clk_100mhz;

   // scoreboard
   logic [13:0] exp_q[$];
   logic [13:0] cur_exp;
   logic        ft_exp;
   int          c;
   int          checks;
   int          errors;
   vec_t        vecs[NVEC];

   function automatic int model_h();
      return (c / 4) % HT;
   endfunction

   function automatic int model_v();
      return ((c / 4) / HT) % VT;
   endfunction

   // {hsync, vsync, r, g, b} the display should show for one pixel
   function automatic logic [13:0] expect_px(int h, int v, logic [3:0] cat, logic en);
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
      hs = !(h >= HV + HFP && h < HV + HFP + HS);
      vs = !(v >= VV + VFP && v < VV + VFP + VS);
      rgb = 12'h000;
      if (h < HV && v < VV && en) begin
         if (cat == 4'd1) rgb = 12'h888;
         else if (cat == 4'd2) rgb = 12'h0F0;
         else if (cat != 4'd0) rgb = 12'hF0F;
      end
      return {hs, vs, rgb};
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (clk %0d)", name, act, exp, c);
      end
   endtask

   // driver: one clock, model update, and per-clock output compare
   task automatic tick();
      logic ft_next;
      ft_next = 1'b0;
      if (rst_n && (c % 4 == 3)) begin
         exp_q.push_back(expect_px(model_h(), model_v(), bus.category, bus.video_en));
         ft_next = (model_h() == HV - 1) && (model_v() == VV - 1);
      end
      @(posedge clk_100mhz);
      if (!rst_n) begin
         c = 0;
         exp_q.delete();
         cur_exp = 14'h3000;
      end else begin
         c++;
         if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
      end
      ft_exp = ft_next;
      @(negedge clk_100mhz);
      chk("pixel_x", int'(bus.pixel_x), model_h());
      chk("pixel_y", int'(bus.pixel_y), model_v());
      chk("sync_rgb", int'({bus.hsync, bus.vsync, bus.vga_r, bus.vga_g, bus.vga_b}),
          int'(cur_exp));
      chk("frame_tick", int'(bus.frame_tick), int'(ft_exp));
   endtask

   task automatic run_to(int x, int y);
      int n;
      n = 0;
      while (!(model_h() == x && model_v() == y && c % 4 == 0) && n < FRAME_CLKS + 8) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int lo_cnt;
      int first_lo_x;
      int ft_cnt;

      vecs[0]  = '{5, 5, 4'd1, 1'b1, 12'h888};
      vecs[1]  = '{5, 5, 4'd2, 1'b1, 12'h0F0};
      vecs[2]  = '{5, 5, 4'd7, 1'b1, 12'hF0F};
      vecs[3]  = '{5, 5, 4'd0, 1'b1, 12'h000};
      vecs[4]  = '{5, 5, 4'd15, 1'b1, 12'hF0F};
      vecs[5]  = '{5, 5, 4'd3, 1'b1, 12'hF0F};
      vecs[6]  = '{26, 5, 4'd2, 1'b1, 12'h000};
      vecs[7]  = '{5, 16, 4'd2, 1'b1, 12'h000};
      vecs[8]  = '{5, 5, 4'd2, 1'b0, 12'h000};
      vecs[9]  = '{19, 11, 4'd2, 1'b1, 12'h0F0};
      vecs[10] = '{20, 11, 4'd2, 1'b1, 12'h000};
      vecs[11] = '{19, 12, 4'd2, 1'b1, 12'h000};

      c = 0;
      checks = 0;
      errors = 0;
      cur_exp = 14'h3000;
      ft_exp = 1'b0;
      bus.category = 4'd0;
      bus.video_en = 1'b1;

      // reset state
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_pixel_x", int'(bus.pixel_x), 0);
      chk("rst_pixel_y", int'(bus.pixel_y), 0);
      chk("rst_hsync", int'(bus.hsync), 1);
      chk("rst_vsync", int'(bus.vsync), 1);
      chk("rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
      chk("rst_frame_tick", int'(bus.frame_tick), 0);

      // first line: release latency, hsync width/position, line wrap
      rst_n = 1'b1;
      lo_cnt = 0;
      first_lo_x = -1;
      for (int i = 0; i < LINE_CLKS; i++) begin
         tick();
         if (i == 2) chk("release_hold_x", int'(bus.pixel_x), 0);
         if (i == 3) chk("first_pix_en_x", int'(bus.pixel_x), 1);
         if (!bus.hsync) begin
            if (first_lo_x < 0) first_lo_x = int'(bus.pixel_x);
            lo_cnt++;
         end
      end
      chk("line_wrap_x", int'(bus.pixel_x), 0);
      chk("line_wrap_y", int'(bus.pixel_y), 1);
      chk("hsync_low_clks", lo_cnt, HS * 4);
      chk("hsync_first_x", first_lo_x, HV + HFP + 1);

      // one full frame: vsync width, single frame_tick, frame period
      lo_cnt = 0;
      ft_cnt = 0;
      for (int i = 0; i < FRAME_CLKS; i++) begin
         tick();
         if (!bus.vsync) lo_cnt++;
         if (bus.frame_tick) begin
            ft_cnt++;
            chk("frame_tick_x", int'(bus.pixel_x), HV);
            chk("frame_tick_y", int'(bus.pixel_y), VV - 1);
         end
      end
      chk("vsync_low_clks", lo_cnt, VS * HT * 4);
      chk("frame_tick_count", ft_cnt, 1);
      chk("frame_repeat_x", int'(bus.pixel_x), 0);
      chk("frame_repeat_y", int'(bus.pixel_y), 1);

      // colour / blanking vectors
      for (int i = 0; i < NVEC; i++) begin
         run_to(vecs[i].x, vecs[i].y);
         bus.category = vecs[i].cat;
         bus.video_en = vecs[i].en;
         repeat (4) tick();
         chk($sformatf("vec%0d_rgb", i), int'({bus.vga_r, bus.vga_g, bus.vga_b}),
             int'(vecs[i].rgb));
      end
      bus.video_en = 1'b1;

      // random categories and video_en over two frames
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         if ($urandom_range(0, 3) == 0) bus.category = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) bus.video_en = ~bus.video_en;
         tick();
      end
      bus.video_en = 1'b1;

      // reset mid-frame, mid-pixel, while both syncs are active
      run_to(26, 15);
      tick();
      tick();
      chk("pre_rst_hsync", int'(bus.hsync), 0);
      chk("pre_rst_vsync", int'(bus.vsync), 0);
      rst_n = 1'b0;
      tick();
      tick();
      chk("mid_rst_pixel_x", int'(bus.pixel_x), 0);
      chk("mid_rst_pixel_y", int'(bus.pixel_y), 0);
      chk("mid_rst_hsync", int'(bus.hsync), 1);
      chk("mid_rst_vsync", int'(bus.vsync), 1);
      chk("mid_rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("mid_release_hold_x", int'(bus.pixel_x), 0);
      tick();
      chk("mid_first_pix_en_x", int'(bus.pixel_x), 1);
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
